// File: rtl/pspin_csr_pkg.sv
// pspin_csr_pkg: register block map constants and helpers for the PsPIN CSR backend
package pspin_csr_pkg;
  localparam logic [3:0] BLK_CTRL = 4'h0;
  localparam logic [3:0] BLK_STATUS = 4'h1;
  localparam logic [3:0] BLK_STATS = 4'h2;
  localparam logic [3:0] BLK_ERR = 4'h3;
  localparam logic [3:0] BLK_CFG = 4'h4;
  localparam logic [3:0] BLK_STDOUT = 4'h5;
  localparam int ERR_STICKY_WORD = 0;
  localparam int ERR_MASK_WORD = 1;
  localparam logic [63:0] RD_INVALID = '1;
  function automatic int words(input int n, input int dw);
    return (n + dw - 1) / dw;
  endfunction
endpackage

// File: rtl/pspin_csr_sat_counter.sv
// pspin_csr_sat_counter: event counter with clear and an all-ones flag used to stop at saturation
module pspin_csr_sat_counter import pspin_csr_pkg::*; #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inc,
  input  logic                 clr,
  output logic                 sat,
  output logic [CNT_WIDTH-1:0] cnt
);
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  // clear restarts from the same-cycle event; the caller withholds inc once saturated
  always_comb begin
    cnt_d = clr ? CNT_WIDTH'(inc) : cnt_q + CNT_WIDTH'(inc);
    sat = &cnt_q;
    cnt = cnt_q;
  end
  // count register
  always_ff @(posedge clk) cnt_q <= rst ? '0 : cnt_d;
endmodule

// File: rtl/pspin_csr_block.sv
// pspin_csr_block: parametrised PsPIN control/status register backend behind a reg-interface bridge
module pspin_csr_block import pspin_csr_pkg::*; #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int NUM_CLUSTERS = 2,
  parameter int NUM_MPQ = 16,
  parameter int NUM_STDOUT = 2,
  parameter int NUM_CNT = 4,
  parameter int CNT_WIDTH = 32,
  parameter int ERR_WIDTH = 8,
  parameter int NUM_CFG = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ADDR_WIDTH-1:0]          reg_wr_addr,
  input  logic [DATA_WIDTH-1:0]          reg_wr_data,
  input  logic [STRB_WIDTH-1:0]          reg_wr_strb,
  input  logic                           reg_wr_en,
  output logic                           reg_wr_wait,
  output logic                           reg_wr_ack,
  input  logic [ADDR_WIDTH-1:0]          reg_rd_addr,
  input  logic                           reg_rd_en,
  output logic [DATA_WIDTH-1:0]          reg_rd_data,
  output logic                           reg_rd_wait,
  output logic                           reg_rd_ack,
  output logic [NUM_CLUSTERS-1:0]        cl_fetch_en_o,
  output logic                           aux_rst_o,
  input  logic [NUM_CLUSTERS-1:0]        cl_eoc_i,
  input  logic [NUM_CLUSTERS-1:0]        cl_busy_i,
  input  logic [NUM_MPQ-1:0]             mpq_full_i,
  input  logic [NUM_STDOUT*32-1:0]       stdout_dout_i,
  input  logic [NUM_STDOUT-1:0]          stdout_valid_i,
  output logic [NUM_STDOUT-1:0]          stdout_rd_en_o,
  input  logic [NUM_CNT-1:0]             cnt_evt_i,
  input  logic [ERR_WIDTH-1:0]           err_i,
  output logic                           irq_o,
  output logic [NUM_CFG*DATA_WIDTH-1:0]  cfg_o,
  output logic [NUM_CFG-1:0]             cfg_wr_pulse_o
);
  localparam int DW = DATA_WIDTH;
  localparam int SB = $clog2(STRB_WIDTH);
  localparam int WNC = words(NUM_CLUSTERS, DATA_WIDTH);
  localparam int WNM = words(NUM_MPQ, DATA_WIDTH);
  logic rd_acc, wr_acc, rd_ack_q, rd_ack_d, wr_ack_q, wr_ack_d, aux_rst_q, aux_rst_d, irq_q, irq_d;
  logic [3:0] rblk, wblk;
  int ro, wo;
  logic [DW-1:0] bm, rd_data_q, rd_data_d;
  logic [NUM_CLUSTERS-1:0] fetch_en_q, fetch_en_d, eoc_q, busy_q;
  logic [NUM_MPQ-1:0] mpq_q;
  logic [NUM_STDOUT-1:0] pop_q, pop_d;
  logic [NUM_CNT-1:0] cnt_clr, cnt_inc, cnt_sat;
  logic [CNT_WIDTH-1:0] cnt [NUM_CNT];
  logic [ERR_WIDTH-1:0] err_q, err_d, mask_q, mask_d;
  logic [DW-1:0] cfg_q [NUM_CFG];
  logic [DW-1:0] cfg_d [NUM_CFG];
  logic [NUM_CFG-1:0] cfg_pulse_q, cfg_pulse_d;
  // handshake acceptance, address split and byte-strobe expansion
  always_comb begin
    rd_acc = reg_rd_en && !rd_ack_q;
    wr_acc = reg_wr_en && !wr_ack_q;
    rblk = reg_rd_addr[15:12];
    wblk = reg_wr_addr[15:12];
    ro = {20'd0, reg_rd_addr[11:0]} >> SB;
    wo = {20'd0, reg_wr_addr[11:0]} >> SB;
    for (int b = 0; b < STRB_WIDTH; b++) bm[b*8 +: 8] = {8{reg_wr_strb[b]}};
  end
  // read decode against pre-write state; stdout pops only on an accepted read of a valid channel
  always_comb begin
    rd_ack_d = rd_acc;
    rd_data_d = rd_data_q;
    pop_d = '0;
    if (rd_acc) begin
      rd_data_d = RD_INVALID[DW-1:0];
      if (rblk == BLK_CTRL && ro <= WNC) rd_data_d = '0;
      if (rblk == BLK_STATUS && ro < 2 * WNC + WNM) rd_data_d = '0;
      if (rblk == BLK_STATS && ro <= NUM_CNT) rd_data_d = '0;
      if (rblk == BLK_ERR && ro == ERR_STICKY_WORD) rd_data_d = DW'(err_q);
      if (rblk == BLK_ERR && ro == ERR_MASK_WORD) rd_data_d = DW'(mask_q);
      for (int i = 0; i < NUM_CLUSTERS; i++) begin
        if (rblk == BLK_CTRL && ro == i / DW) rd_data_d[i%DW] = fetch_en_q[i];
        if (rblk == BLK_STATUS && ro == i / DW) rd_data_d[i%DW] = eoc_q[i];
        if (rblk == BLK_STATUS && ro == WNC + i / DW) rd_data_d[i%DW] = busy_q[i];
      end
      if (rblk == BLK_CTRL && ro == WNC) rd_data_d[0] = aux_rst_q;
      for (int i = 0; i < NUM_MPQ; i++)
        if (rblk == BLK_STATUS && ro == 2 * WNC + i / DW) rd_data_d[i%DW] = mpq_q[i];
      for (int k = 0; k < NUM_CNT; k++)
        if (rblk == BLK_STATS && ro == k) rd_data_d = DW'(cnt[k]);
      for (int k = 0; k < NUM_CFG; k++)
        if (rblk == BLK_CFG && ro == k) rd_data_d = cfg_q[k];
      for (int k = 0; k < NUM_STDOUT; k++)
        if (rblk == BLK_STDOUT && ro == k) begin
          rd_data_d = stdout_valid_i[k] ? DW'(stdout_dout_i[k*32 +: 32]) : RD_INVALID[DW-1:0];
          pop_d[k] = stdout_valid_i[k];
        end
    end
  end
  // write decode; error sets from err_i are applied after W1C so they win
  always_comb begin
    wr_ack_d = wr_acc;
    fetch_en_d = fetch_en_q;
    aux_rst_d = aux_rst_q;
    err_d = err_q;
    mask_d = mask_q;
    cfg_d = cfg_q;
    cfg_pulse_d = '0;
    cnt_clr = '0;
    irq_d = |(err_q & mask_q);
    if (wr_acc) begin
      for (int i = 0; i < NUM_CLUSTERS; i++)
        if (wblk == BLK_CTRL && wo == i / DW && bm[i%DW]) fetch_en_d[i] = reg_wr_data[i%DW];
      if (wblk == BLK_CTRL && wo == WNC && bm[0]) aux_rst_d = reg_wr_data[0];
      if (wblk == BLK_STATS && wo == NUM_CNT) cnt_clr = reg_wr_data[NUM_CNT-1:0] & bm[NUM_CNT-1:0];
      for (int i = 0; i < ERR_WIDTH; i++) begin
        if (wblk == BLK_ERR && wo == ERR_STICKY_WORD && bm[i] && reg_wr_data[i]) err_d[i] = 1'b0;
        if (wblk == BLK_ERR && wo == ERR_MASK_WORD && bm[i]) mask_d[i] = reg_wr_data[i];
      end
      for (int k = 0; k < NUM_CFG; k++)
        if (wblk == BLK_CFG && wo == k) begin
          cfg_d[k] = (cfg_q[k] & ~bm) | (reg_wr_data & bm);
          cfg_pulse_d[k] = 1'b1;
        end
    end
    err_d = err_d | err_i;
    cnt_inc = cnt_evt_i & (~cnt_sat | cnt_clr);
  end
  for (genvar k = 0; k < NUM_CNT; k++) begin : g_cnt
    pspin_csr_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_cnt (
      .clk(clk),
      .rst(rst),
      .inc(cnt_inc[k]),
      .clr(cnt_clr[k]),
      .sat(cnt_sat[k]),
      .cnt(cnt[k])
    );
  end
  // state registers and status sampling
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ack_q <= 1'b0;
      wr_ack_q <= 1'b0;
      rd_data_q <= '0;
      fetch_en_q <= '0;
      aux_rst_q <= 1'b1;
      eoc_q <= '0;
      busy_q <= '0;
      mpq_q <= '0;
      pop_q <= '0;
      err_q <= '0;
      mask_q <= '0;
      irq_q <= 1'b0;
      cfg_q <= '{default: '0};
      cfg_pulse_q <= '0;
    end else begin
      rd_ack_q <= rd_ack_d;
      wr_ack_q <= wr_ack_d;
      rd_data_q <= rd_data_d;
      fetch_en_q <= fetch_en_d;
      aux_rst_q <= aux_rst_d;
      eoc_q <= cl_eoc_i;
      busy_q <= cl_busy_i;
      mpq_q <= mpq_full_i;
      pop_q <= pop_d;
      err_q <= err_d;
      mask_q <= mask_d;
      irq_q <= irq_d;
      cfg_q <= cfg_d;
      cfg_pulse_q <= cfg_pulse_d;
    end
  end
  // flatten config words onto the output bus
  always_comb for (int k = 0; k < NUM_CFG; k++) cfg_o[k*DW +: DW] = cfg_q[k];
  assign reg_wr_wait = 1'b0;
  assign reg_rd_wait = 1'b0;
  assign reg_wr_ack = wr_ack_q;
  assign reg_rd_ack = rd_ack_q;
  assign reg_rd_data = rd_data_q;
  assign cl_fetch_en_o = fetch_en_q;
  assign aux_rst_o = aux_rst_q;
  assign stdout_rd_en_o = pop_q;
  assign irq_o = irq_q;
  assign cfg_wr_pulse_o = cfg_pulse_q;
endmodule
